alu_exec_ctrl: RTL and testbench

//  Sequencing front-end for the WIDTH-bit alu. Accepts one ALU command per valid/ready

---
 rtl/alu_exec_ctrl_pkg.sv | 20 ++
 rtl/alu_exec_ctrl_alu.sv | 54 +++++
 rtl/alu_exec_ctrl.sv | 89 ++++++++
 tb/tb_alu_exec_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared codes for the alu and its sequencing front-end: func_sel encodings and FSM state encodings.
package alu_exec_ctrl_pkg;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_CMP = 3'b010;
    localparam logic [2:0] FUNC_NEG = 3'b011;
    localparam logic [2:0] FUNC_AND = 3'b100;
    localparam logic [2:0] FUNC_OR  = 3'b101;
    localparam logic [2:0] FUNC_XOR = 3'b110;
    localparam logic [2:0] FUNC_ROT = 3'b111;

    // bit of func_sel that picks rotate direction (1 = right)
    localparam int ROT_RIGHT = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_exec_ctrl_alu.sv
// Combinational WIDTH-bit alu: add/sub/compare/negate/logic/rotate-by-one with a single flag output.
module alu
    import alu_exec_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func_sel,
    output logic [WIDTH-1:0] r,
    output logic             ov_sgn
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // ov_sgn is carry-out for add, borrow (a < b unsigned) for sub/compare,
    // and "most negative operand" for negate.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        r      = '0;
        ov_sgn = 1'b0;
        case (func_sel[2:0])
            FUNC_ADD: begin
                r      = sum[WIDTH-1:0];
                ov_sgn = sum[WIDTH];
            end
            FUNC_SUB: begin
                r      = diff[WIDTH-1:0];
                ov_sgn = diff[WIDTH];
            end
            FUNC_CMP: begin
                r      = {{(WIDTH-1){1'b0}}, (a == b)};
                ov_sgn = diff[WIDTH];
            end
            FUNC_NEG: begin
                r      = '0 - a;
                ov_sgn = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            FUNC_AND: r = a & b;
            FUNC_OR:  r = a | b;
            FUNC_XOR: r = a ^ b;
            FUNC_ROT: begin
                if (func_sel[ROT_RIGHT])
                    r = {a[0], a[WIDTH-1:1]};
                else
                    r = {a[WIDTH-2:0], a[WIDTH-1]};
            end
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencing front-end for the alu: command handshake, operand/result/accumulator registers,
// result handshake and completed-operation counter.
//
//   state | meaning
//   IDLE  | waiting for a command; cmd_ready high
//   EXEC  | operands registered, alu result captured at the end of this cycle
//   DONE  | result presented (res_valid); a new command may be accepted as it is taken
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_func,
    input  logic                 cmd_acc_sel,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_r,
    output logic                 res_ov_sgn,
    output logic [WIDTH-1:0]     acc,
    output logic [CNT_WIDTH-1:0] ops_done
);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_func;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ov_sgn;
    logic             cmd_hs;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .func_sel (op_func),
        .r        (alu_r),
        .ov_sgn   (alu_ov_sgn)
    );

    assign cmd_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && res_ready));
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign res_valid = (state == ST_DONE);

    // acc here is the value written by the preceding EXEC, so back-to-back accepts chain correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_func    <= '0;
            res_r      <= '0;
            res_ov_sgn <= 1'b0;
            acc        <= '0;
            ops_done   <= '0;
        end else begin
            if (cmd_hs) begin
                op_a    <= cmd_acc_sel ? acc : cmd_a;
                op_b    <= cmd_b;
                op_func <= cmd_func;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_hs)
                        state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_r      <= alu_r;
                    res_ov_sgn <= alu_ov_sgn;
                    acc        <= alu_r;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        ops_done <= ops_done + CNT_WIDTH'(1);
                        state    <= cmd_hs ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl (WIDTH=4) with hand-computed expected results.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_func;
    logic       cmd_acc_sel;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_r;
    logic       res_ov_sgn;
    logic [3:0] acc;
    logic [7:0] ops_done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt  = 8'd0;

    alu_exec_ctrl #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_func    (cmd_func),
        .cmd_acc_sel (cmd_acc_sel),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_r       (res_r),
        .res_ov_sgn  (res_ov_sgn),
        .acc         (acc),
        .ops_done    (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] f, input logic s, input logic [3:0] a, input logic [3:0] b);
        cmd_valid   = 1'b1;
        cmd_func    = f;
        cmd_acc_sel = s;
        cmd_a       = a;
        cmd_b       = b;
    endtask

    // From IDLE: present a command, pass the accept edge, leave the DUT in EXEC.
    task automatic accept(input logic [3:0] f, input logic s, input logic [3:0] a, input logic [3:0] b);
        drive(f, s, a, b);
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("res_valid_exec", 32'(res_valid), 0);
    endtask

    task automatic expect_result(input logic [3:0] er, input logic eo);
        tick();
        chk("res_valid_done", 32'(res_valid), 1);
        chk("res_r", 32'(res_r), 32'(er));
        chk("res_ov_sgn", 32'(res_ov_sgn), 32'(eo));
        chk("acc", 32'(acc), 32'(er));
    endtask

    task automatic drain();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        #1;
        chk("ops_done", 32'(ops_done), 32'(exp_cnt));
        chk("res_valid_idle", 32'(res_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_func    = 4'h0;
        cmd_acc_sel = 1'b0;
        cmd_a       = 4'h0;
        cmd_b       = 4'h0;
        res_ready   = 1'b0;

        tick();
        chk("cmd_ready_in_rst", 32'(cmd_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_r", 32'(res_r), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_ops_done", 32'(ops_done), 0);

        // add 3+5, then 8+8 (carry out, wraps to 0)
        accept(4'b0000, 1'b0, 4'd3, 4'd5);
        expect_result(4'd8, 1'b0);
        drain();
        accept(4'b0000, 1'b0, 4'd8, 4'd8);
        expect_result(4'd0, 1'b1);
        drain();

        // remaining functions
        accept(4'b0001, 1'b0, 4'd3, 4'd5);   // sub, borrow
        expect_result(4'hE, 1'b1);
        drain();
        accept(4'b0010, 1'b0, 4'd5, 4'd5);   // compare equal
        expect_result(4'h1, 1'b0);
        drain();
        accept(4'b0011, 1'b0, 4'd3, 4'd0);   // negate
        expect_result(4'hD, 1'b0);
        drain();
        accept(4'b0011, 1'b0, 4'd8, 4'd0);   // negate most-negative
        expect_result(4'h8, 1'b1);
        drain();
        accept(4'b0100, 1'b0, 4'hC, 4'hA);
        expect_result(4'h8, 1'b0);
        drain();
        accept(4'b0101, 1'b0, 4'hC, 4'hA);
        expect_result(4'hE, 1'b0);
        drain();

        // back-to-back: add 3+5 then XOR acc with F, accepted while in DONE
        accept(4'b0000, 1'b0, 4'd3, 4'd5);
        expect_result(4'd8, 1'b0);
        drive(4'b0110, 1'b1, 4'd0, 4'hF);
        res_ready = 1'b1;
        #1;
        chk("cmd_ready_done", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        #1;
        chk("b2b_ops_done", 32'(ops_done), 32'(exp_cnt));
        chk("b2b_exec", 32'(res_valid), 0);
        expect_result(4'd7, 1'b0);
        drain();

        // stall in DONE for 5 cycles, then release with a pending command
        accept(4'b0000, 1'b0, 4'd1, 4'd1);
        expect_result(4'd2, 1'b0);
        drive(4'b0000, 1'b0, 4'd2, 4'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_r", 32'(res_r), 2);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            chk("stall_ops_done", 32'(ops_done), 32'(exp_cnt));
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("release_cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        #1;
        chk("release_ops_done", 32'(ops_done), 32'(exp_cnt));
        expect_result(4'd4, 1'b0);
        drain();

        // rotate right then left
        accept(4'b1111, 1'b0, 4'b0001, 4'd0);
        expect_result(4'b1000, 1'b0);
        drain();
        accept(4'b0111, 1'b0, 4'b1000, 4'd0);
        expect_result(4'b0001, 1'b0);
        drain();

        // reset while in EXEC drops the command
        accept(4'b0000, 1'b0, 4'd1, 4'd1);
        rst = 1'b1;
        #1;
        chk("rst_exec_cmd_ready", 32'(cmd_ready), 0);
        tick();
        chk("rst_exec_valid", 32'(res_valid), 0);
        chk("rst_exec_acc", 32'(acc), 0);
        chk("rst_exec_r", 32'(res_r), 0);
        chk("rst_exec_ops_done", 32'(ops_done), 0);
        rst     = 1'b0;
        exp_cnt = 8'd0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        tick();
        chk("post_rst_no_result", 32'(res_valid), 0);

        accept(4'b0000, 1'b0, 4'd1, 4'd2);
        expect_result(4'd3, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
